// File: rtl/pwm_cap_pkg.sv
// pwm_cap_pkg
// Shared types and default constants for the PWM/square-wave capture block.
//   pwm_cap_state_t     - measurement FSM state encoding
//   PWM_CAP_CNT_W       - default width of the period/high-time counters
//   PWM_CAP_TIMEOUT_CYC - default loss-of-signal timeout in clk cycles
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } pwm_cap_state_t;

    localparam int PWM_CAP_CNT_W       = 28;
    localparam int PWM_CAP_TIMEOUT_CYC = 100_000_000;

endpackage

// File: rtl/sig_sync_edge.sv
// sig_sync_edge
// Conditions an asynchronous input: 2-FF synchronizer, optional glitch
// filter (enabled by defining PWM_CAP_GLITCH_FILT_EN), and edge detector.
// Reusable for any slow asynchronous input (tones, buttons, ...).
//   clk    - system clock
//   arst   - asynchronous active-high reset
//   sig_in - asynchronous input
//   level  - conditioned level (sig_f)
//   rise   - one-cycle strobe on a conditioned 0->1 transition
//   fall   - one-cycle strobe on a conditioned 1->0 transition
// FILT_LEN: with the filter enabled, the conditioned level follows the
// synchronized input only after it has held a new level for FILT_LEN cycles.
module sig_sync_edge
    import pwm_cap_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic arst,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("sig_sync_edge: FILT_LEN must be at least 1");
    end

    logic sync_1;
    logic sig_s;
    logic sig_f;
    logic sig_f_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_1 <= 1'b0;
            sig_s  <= 1'b0;
        end else begin
            sync_1 <= sig_in;
            sig_s  <= sync_1;
        end
    end

`ifdef PWM_CAP_GLITCH_FILT_EN
    localparam int STAB_W = $clog2(FILT_LEN + 1);

    // stab_cnt counts consecutive cycles in which sig_s disagrees with sig_f;
    // any return to agreement restarts the count, so short pulses never pass.
    logic [STAB_W-1:0] stab_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sig_f    <= 1'b0;
            stab_cnt <= '0;
        end else if (sig_s == sig_f) begin
            stab_cnt <= '0;
        end else if (stab_cnt == STAB_W'(FILT_LEN - 1)) begin
            sig_f    <= sig_s;
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end
`else
    assign sig_f = sig_s;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sig_f_q <= 1'b0;
        end else begin
            sig_f_q <= sig_f;
        end
    end

    assign level = sig_f;
    assign rise  = sig_f & ~sig_f_q;
    assign fall  = ~sig_f & sig_f_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// Measures period and high time of an asynchronous PWM/square-wave input in
// clk cycles and flags loss of signal after TIMEOUT_CYC cycles without a rise.
// Optional glitch filter: define PWM_CAP_GLITCH_FILT_EN.
//   clk        - system clock
//   arst       - asynchronous active-high reset
//   sig_in     - measured signal (asynchronous)
//   period_cnt - cycles between the last two rising edges
//   high_cnt   - high time within that period
//   meas_valid - one-cycle strobe when period_cnt/high_cnt are loaded
//   no_signal  - high until the first measurement and after a timeout
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no reference edge yet (or timed out); counter held at 0
// MEAS_HIGH | counting the high phase after a rising edge
// MEAS_LOW  | counting the low phase; next rise completes a period
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W       = PWM_CAP_CNT_W,
    parameter int TIMEOUT_CYC = PWM_CAP_TIMEOUT_CYC,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             no_signal
);

    if (TIMEOUT_CYC < 1 || longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT_CYC must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic sig_rise;
    logic sig_fall;
    // The conditioned level is not needed by this block.
    logic sig_level_unused;

    sig_sync_edge #(
        .FILT_LEN (FILT_LEN)
    ) u_sync_edge (
        .clk    (clk),
        .arst   (arst),
        .sig_in (sig_in),
        .level  (sig_level_unused),
        .rise   (sig_rise),
        .fall   (sig_fall)
    );

    pwm_cap_state_t   state,      state_n;
    logic [CNT_W-1:0] cnt,        cnt_n;
    logic [CNT_W-1:0] high_cap,   high_cap_n;
    logic [CNT_W-1:0] period_n,   high_n;
    logic             valid_n,    no_signal_n;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            cnt        <= '0;
            high_cap   <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            high_cap   <= high_cap_n;
            period_cnt <= period_n;
            high_cnt   <= high_n;
            meas_valid <= valid_n;
            no_signal  <= no_signal_n;
        end
    end

    // The counter is loaded with 1 on the edge that samples rise, so its value
    // when the next fall/rise is sampled equals the elapsed cycles directly.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        high_cap_n  = high_cap;
        period_n    = period_cnt;
        high_n      = high_cnt;
        valid_n     = 1'b0;
        no_signal_n = no_signal;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (sig_rise) begin
                    cnt_n   = CNT_ONE;
                    state_n = MEAS_HIGH;
                end
            end

            MEAS_HIGH: begin
                if (cnt == TIMEOUT_VAL) begin
                    cnt_n       = '0;
                    no_signal_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                    if (sig_fall) begin
                        high_cap_n = cnt;
                        state_n    = MEAS_LOW;
                    end
                end
            end

            MEAS_LOW: begin
                // A rise on the threshold cycle still completes the period.
                if (sig_rise) begin
                    period_n    = cnt;
                    high_n      = high_cap;
                    valid_n     = 1'b1;
                    no_signal_n = 1'b0;
                    cnt_n       = CNT_ONE;
                    state_n     = MEAS_HIGH;
                end else if (cnt == TIMEOUT_VAL) begin
                    cnt_n       = '0;
                    no_signal_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Two instances share one stimulus: dut_long (timeout 20000) measures the
// long test waves, dut_short (timeout 1000) exercises loss of signal.
// The reference model works on the driven waveform: each rising edge closes
// a period of (rise - previous rise) cycles with high time (fall - previous
// rise), reported only when the previous rise exists and the gap does not
// exceed the timeout. Strobes are expected a fixed pipeline latency after
// the driven edge.
module tb_pwm_capture;

    localparam int CNT_W    = 28;
    localparam int T0       = 20000;
    localparam int T1       = 1000;
    localparam int FILT_LEN = 4;
`ifdef PWM_CAP_GLITCH_FILT_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic sig_in = 1'b0;

    logic [CNT_W-1:0] pc0, hc0, pc1, hc1;
    logic             mv0, ns0, mv1, ns1;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(T0), .FILT_LEN(FILT_LEN)) dut_long (
        .clk(clk), .arst(arst), .sig_in(sig_in),
        .period_cnt(pc0), .high_cnt(hc0), .meas_valid(mv0), .no_signal(ns0)
    );

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(T1), .FILT_LEN(FILT_LEN)) dut_short (
        .clk(clk), .arst(arst), .sig_in(sig_in),
        .period_cnt(pc1), .high_cnt(hc1), .meas_valid(mv1), .no_signal(ns1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p;
        int h;
        int c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   last_p[2];
    int   last_h[2];
    int   f_lvl;
    int   pend;
    bit   armed[2];
    int   t_rise[2];
    int   t_fall[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int j, input int p, input int h, input int c);
        exp_t e;
        e.p = p;
        e.h = h;
        e.c = c;
        if (j == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        f_lvl = 0;
        pend  = -1;
        for (int j = 0; j < 2; j++) begin
            armed[j]  = 1'b0;
            t_rise[j] = 0;
            t_fall[j] = 0;
            last_p[j] = 0;
            last_h[j] = 0;
        end
    endtask

    task automatic model_edge(input int v, input int te);
        int tmo;
        f_lvl = v;
        for (int j = 0; j < 2; j++) begin
            tmo = (j == 0) ? T0 : T1;
            if (v != 0) begin
                if (armed[j] && (te - t_rise[j]) <= tmo)
                    push(j, te - t_rise[j], t_fall[j] - t_rise[j], te + LAT);
                armed[j]  = 1'b1;
                t_rise[j] = te;
            end else begin
                t_fall[j] = te;
            end
        end
    endtask

    task automatic model_step(input int v, input int t);
`ifdef PWM_CAP_GLITCH_FILT_EN
        if (v != f_lvl) begin
            if (pend < 0) pend = t;
            if (t - pend + 1 >= FILT_LEN) begin
                model_edge(v, pend);
                pend = -1;
            end
        end else begin
            pend = -1;
        end
`else
        if (v != f_lvl) model_edge(v, t);
`endif
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            sig_in = v;
            if (!arst) model_step(int'(v), cyc);
        end
    endtask

    task automatic wave(input int h, input int l, input int periods);
        repeat (periods) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic mon(input int j, input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h,
                       input logic v, input logic n);
        exp_t e;
        int   sz;
        sz = (j == 0) ? q0.size() : q1.size();
        if (sz > 0) e = (j == 0) ? q0[0] : q1[0];
        if (v) begin
            if (sz == 0) begin
                chk($sformatf("d%0d_unexpected_strobe", j), 32'(v), 32'd0);
            end else begin
                chk($sformatf("d%0d_period", j), 32'(p), e.p);
                chk($sformatf("d%0d_high", j), 32'(h), e.h);
                chk($sformatf("d%0d_strobe_cycle", j), cyc, e.c);
                chk($sformatf("d%0d_no_signal_at_strobe", j), 32'(n), 32'd0);
                last_p[j] = e.p;
                last_h[j] = e.h;
                if (j == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end else begin
            chk($sformatf("d%0d_period_stable", j), 32'(p), last_p[j]);
            chk($sformatf("d%0d_high_stable", j), 32'(h), last_h[j]);
            if (sz > 0 && e.c < cyc) begin
                chk($sformatf("d%0d_missing_strobe", j), 32'(v), 32'd1);
                if (j == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (started && !arst) begin
            mon(0, pc0, hc0, mv0, ns0);
            mon(1, pc1, hc1, mv1, ns1);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_d0_period"}, 32'(pc0), 32'd0);
        chk({tag, "_d0_high"}, 32'(hc0), 32'd0);
        chk({tag, "_d0_valid"}, 32'(mv0), 32'd0);
        chk({tag, "_d0_no_signal"}, 32'(ns0), 32'd1);
        chk({tag, "_d1_period"}, 32'(pc1), 32'd0);
        chk({tag, "_d1_valid"}, 32'(mv1), 32'd0);
        chk({tag, "_d1_no_signal"}, 32'(ns1), 32'd1);
    endtask

    initial begin
        int d;
        int h;
        int l;

        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        @(negedge clk);
        arst = 1'b0;
        started = 1'b1;

        // Symmetric 5000/5000: first strobe on the second rise.
        drive(1'b0, 10);
        wave(5000, 5000, 1);
        chk("sym_no_signal_before_first", 32'(ns0), 32'd1);
        wave(5000, 5000, 1);
        drive(1'b1, LAT + 2);
        chk("sym_period", 32'(pc0), 32'd10000);
        chk("sym_high", 32'(hc0), 32'd5000);
        chk("sym_no_signal", 32'(ns0), 32'd0);
        chk("sym_short_timed_out", 32'(ns1), 32'd1);

        // Period change 5000/5000 -> 7000/7000 at a rising edge.
        drive(1'b1, 5000 - (LAT + 2));
        drive(1'b0, 5000);
        wave(7000, 7000, 1);
        drive(1'b1, LAT + 2);
        chk("change_period", 32'(pc0), 32'd14000);
        chk("change_high", 32'(hc0), 32'd7000);

        // Asymmetric and minimum widths.
        drive(1'b0, 7);
        wave(3, 7, 4);
        drive(1'b1, LAT + 2);
`ifndef PWM_CAP_GLITCH_FILT_EN
        chk("asym_period", 32'(pc1), 32'd10);
        chk("asym_high", 32'(hc1), 32'd3);
`endif
        drive(1'b0, 1);
        wave(1, 1, 6);
        drive(1'b1, LAT + 2);
`ifndef PWM_CAP_GLITCH_FILT_EN
        chk("min_period", 32'(pc0), 32'd2);
        chk("min_high", 32'(hc0), 32'd1);
        chk("min_no_signal", 32'(ns1), 32'd0);
`endif

        // Random widths against the model.
        drive(1'b0, 5);
        for (int i = 0; i < 30; i++) begin
            h = int'($urandom_range(1, 40));
            l = int'($urandom_range(1, 40));
            wave(h, l, 1);
        end
        drive(1'b1, LAT + 2);

        // Timeout boundary on dut_short: gap 1000 measured, gap 1001 times out.
        drive(1'b0, 10);
        wave(300, 700, 2);
        wave(300, 701, 1);
        wave(300, 700, 1);
        drive(1'b1, LAT + 2);
        chk("boundary_period", 32'(pc1), 32'd1000);
        chk("boundary_high", 32'(hc1), 32'd300);

        // Stuck high: no_signal rises exactly TIMEOUT cycles after the rise.
        drive(1'b0, 40);
        wave(50, 50, 3);
        d = 0;
        for (int k = 0; k < T1 + 20; k++) begin
            drive(1'b1, 1);
            if (k == 0) d = cyc;
            if (cyc == d + LAT + T1 - 1) chk("timeout_not_yet", 32'(ns1), 32'd0);
            if (cyc == d + LAT + T1)     chk("timeout_flag", 32'(ns1), 32'd1);
        end
        chk("timeout_keep_period", 32'(pc1), 32'd100);
        chk("timeout_keep_high", 32'(hc1), 32'd50);

        // Resume 50/50: one rise is not enough, the second one reports 100/50.
        drive(1'b0, 50);
        drive(1'b1, 50);
        chk("resume_first_rise", 32'(ns1), 32'd1);
        drive(1'b0, 50);
        wave(50, 50, 1);
        drive(1'b1, LAT + 2);
        chk("resume_period", 32'(pc1), 32'd100);
        chk("resume_high", 32'(hc1), 32'd50);
        chk("resume_no_signal", 32'(ns1), 32'd0);

        // 2-cycle low glitch inside the high phase of a 100/100 wave.
        drive(1'b0, 100);
        wave(100, 100, 2);
        repeat (2) begin
            drive(1'b1, 40);
            drive(1'b0, 2);
            drive(1'b1, 58);
            drive(1'b0, 100);
        end
        drive(1'b1, LAT + 2);
`ifdef PWM_CAP_GLITCH_FILT_EN
        chk("glitch_period", 32'(pc0), 32'd200);
        chk("glitch_high", 32'(hc0), 32'd100);
`endif

        // Reset in the middle of a high phase of a 200/200 wave.
        drive(1'b1, 200 - (LAT + 2));
        drive(1'b0, 200);
        wave(200, 200, 2);
        drive(1'b1, 100);
        chk("pre_reset_queue0", q0.size(), 32'd0);
        chk("pre_reset_queue1", q1.size(), 32'd0);
        @(negedge clk);
        arst = 1'b1;
        model_reset();
        drive(1'b1, 20);
        chk_reset_vals("midreset");
        drive(1'b0, 10);
        @(negedge clk);
        arst = 1'b0;
        drive(1'b0, 20);
        wave(200, 200, 1);
        chk("post_reset_one_rise", 32'(ns0), 32'd1);
        chk("post_reset_period_held", 32'(pc0), 32'd0);
        wave(200, 200, 1);
        drive(1'b1, LAT + 2);
        chk("post_reset_period", 32'(pc0), 32'd400);
        chk("post_reset_high", 32'(hc0), 32'd200);
        chk("post_reset_no_signal", 32'(ns0), 32'd0);

        drive(1'b0, 20);
        chk("end_queue0", q0.size(), 32'd0);
        chk("end_queue1", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
